// File: rtl/vxe_cu_pkg.sv
// rtl/vxe_cu_pkg.sv - shared state encoding for the VxE control unit
package vxe_cu_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RUN   = 3'd1;
    localparam logic [2:0] ST_SYNC  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_SYNC  = ST_SYNC,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } cu_state_t;

endpackage

// File: rtl/vxe_cu_exec_unit.sv
// rtl/vxe_cu_exec_unit.sv - execution-control FSM of the VxE control unit
//
// Starts a program on i_start, handles SYNC / SYNC-STOP / SYNC-INTR commands
// and fetch/decode/VPU faults, and drives halt/unhalt/drain/interrupt/complete
// controls to the fetch, dispatch and forward stages.
//
// Ports:
//   clk, nrst            clock, asynchronous active-low reset
//   i_start              start pulse (honoured only in IDLE)
//   i_cmd_*              decoded command pulses and sync qualifiers
//   i_fetch_busy, i_dis_pipes_active, i_fwd_pipes_active, i_vpus_busy
//                        pipeline activity levels
//   i_flt_fetch, i_flt_decode, i_vpus_err
//                        fault pulses
//   o_glb_busy           engine executing (RUN..DONE)
//   o_halt, o_unhalt     1-cycle fetch/dispatch halt/resume pulses
//   o_stop_drain         level: stop fetching and drain pending commands
//   o_send_intr          1-cycle interrupt pulse
//   o_complete           1-cycle execution-finished pulse
module vxe_cu_exec_unit
    import vxe_cu_pkg::*;
(
    input  logic clk,
    input  logic nrst,
    input  logic i_start,
    output logic o_glb_busy,
    output logic o_halt,
    output logic o_unhalt,
    output logic o_stop_drain,
    output logic o_send_intr,
    output logic o_complete,
    input  logic i_cmd_nop,
    input  logic i_cmd_sync,
    input  logic i_cmd_sync_stop,
    input  logic i_cmd_sync_intr,
    input  logic i_fetch_busy,
    input  logic i_dis_pipes_active,
    input  logic i_fwd_pipes_active,
    input  logic i_vpus_busy,
    input  logic i_flt_fetch,
    input  logic i_flt_decode,
    input  logic i_vpus_err
);

    cu_state_t state, state_nxt;
    logic      intr_flag, intr_flag_nxt;   // interrupt owed at DONE
    logic      sync_intr, sync_intr_nxt;   // interrupt owed at end of plain SYNC
    logic      busy_nxt, halt_nxt, unhalt_nxt, drain_nxt, intr_nxt, cpl_nxt;

    logic fault, drain_idle, sync_idle;

    assign fault      = i_flt_fetch | i_flt_decode | i_vpus_err;
    assign drain_idle = ~(i_fetch_busy | i_dis_pipes_active | i_fwd_pipes_active | i_vpus_busy);
    assign sync_idle  = ~(i_fwd_pipes_active | i_vpus_busy);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= S_IDLE;
            intr_flag    <= 1'b0;
            sync_intr    <= 1'b0;
            o_glb_busy   <= 1'b0;
            o_halt       <= 1'b0;
            o_unhalt     <= 1'b0;
            o_stop_drain <= 1'b0;
            o_send_intr  <= 1'b0;
            o_complete   <= 1'b0;
        end else begin
            state        <= state_nxt;
            intr_flag    <= intr_flag_nxt;
            sync_intr    <= sync_intr_nxt;
            o_glb_busy   <= busy_nxt;
            o_halt       <= halt_nxt;
            o_unhalt     <= unhalt_nxt;
            o_stop_drain <= drain_nxt;
            o_send_intr  <= intr_nxt;
            o_complete   <= cpl_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        intr_flag_nxt = intr_flag;
        sync_intr_nxt = sync_intr;
        busy_nxt      = o_glb_busy;
        drain_nxt     = o_stop_drain;
        halt_nxt      = 1'b0;
        unhalt_nxt    = 1'b0;
        intr_nxt      = 1'b0;
        cpl_nxt       = 1'b0;

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    state_nxt  = S_RUN;
                    unhalt_nxt = 1'b1;
                    busy_nxt   = 1'b1;
                end
            end
            S_RUN: begin
                if (fault) begin
                    state_nxt     = S_DRAIN;
                    halt_nxt      = 1'b1;
                    drain_nxt     = 1'b1;
                    intr_flag_nxt = 1'b1;
                end else if (i_cmd_sync && i_cmd_sync_stop) begin
                    state_nxt     = S_DRAIN;
                    halt_nxt      = 1'b1;
                    drain_nxt     = 1'b1;
                    intr_flag_nxt = i_cmd_sync_intr;
                end else if (i_cmd_sync) begin
                    state_nxt     = S_SYNC;
                    halt_nxt      = 1'b1;
                    sync_intr_nxt = i_cmd_sync_intr;
                end else if (i_cmd_nop) begin
                    state_nxt     = S_RUN;
                end
            end
            S_SYNC: begin
                if (fault) begin
                    state_nxt     = S_DRAIN;
                    halt_nxt      = 1'b1;
                    drain_nxt     = 1'b1;
                    intr_flag_nxt = 1'b1;
                    sync_intr_nxt = 1'b0;
                end else if (sync_idle) begin
                    state_nxt     = S_RUN;
                    intr_nxt      = sync_intr;
                    unhalt_nxt    = 1'b1;
                    sync_intr_nxt = 1'b0;
                end
            end
            S_DRAIN: begin
                drain_nxt = 1'b1;
                if (fault) begin
                    intr_flag_nxt = 1'b1;
                end
                if (drain_idle) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Interrupt is a single pulse here even if fault and sync-intr both set the flag.
                cpl_nxt       = 1'b1;
                intr_nxt      = intr_flag;
                drain_nxt     = 1'b0;
                busy_nxt      = 1'b0;
                intr_flag_nxt = 1'b0;
                sync_intr_nxt = 1'b0;
                state_nxt     = S_IDLE;
            end
            default: begin
                state_nxt     = S_IDLE;
                drain_nxt     = 1'b0;
                busy_nxt      = 1'b0;
                intr_flag_nxt = 1'b0;
                sync_intr_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_vxe_cu_exec_unit.sv
// tb/tb_vxe_cu_exec_unit.sv - scoreboard bench for vxe_cu_exec_unit
module tb_vxe_cu_exec_unit;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic i_start = 1'b0;
    logic o_glb_busy, o_halt, o_unhalt, o_stop_drain, o_send_intr, o_complete;
    logic i_cmd_nop = 1'b0, i_cmd_sync = 1'b0, i_cmd_sync_stop = 1'b0, i_cmd_sync_intr = 1'b0;
    logic i_fetch_busy = 1'b0, i_dis_pipes_active = 1'b0, i_fwd_pipes_active = 1'b0, i_vpus_busy = 1'b0;
    logic i_flt_fetch = 1'b0, i_flt_decode = 1'b0, i_vpus_err = 1'b0;

    int total = 0;
    int bad = 0;

    // pulse vector {unhalt, halt, send_intr, complete}
    localparam logic [3:0] EV_UNHALT = 4'b1000;
    localparam logic [3:0] EV_HALT   = 4'b0100;
    localparam logic [3:0] EV_CPL    = 4'b0001;
    localparam logic [3:0] EV_CPL_IN = 4'b0011;
    localparam logic [3:0] EV_IN_UNH = 4'b1010;

    logic [3:0] exp_q[$];

    vxe_cu_exec_unit dut (
        .clk(clk), .nrst(nrst), .i_start(i_start),
        .o_glb_busy(o_glb_busy), .o_halt(o_halt), .o_unhalt(o_unhalt),
        .o_stop_drain(o_stop_drain), .o_send_intr(o_send_intr), .o_complete(o_complete),
        .i_cmd_nop(i_cmd_nop), .i_cmd_sync(i_cmd_sync),
        .i_cmd_sync_stop(i_cmd_sync_stop), .i_cmd_sync_intr(i_cmd_sync_intr),
        .i_fetch_busy(i_fetch_busy), .i_dis_pipes_active(i_dis_pipes_active),
        .i_fwd_pipes_active(i_fwd_pipes_active), .i_vpus_busy(i_vpus_busy),
        .i_flt_fetch(i_flt_fetch), .i_flt_decode(i_flt_decode), .i_vpus_err(i_vpus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Scoreboard: every cycle carrying any pulse must match the next expected event.
    always @(negedge clk) begin
        logic [3:0] ev;
        ev = {o_unhalt, o_halt, o_send_intr, o_complete};
        if (nrst && ev != 4'b0000) begin
            if (exp_q.size() == 0) chk("unexpected_pulse", {28'd0, ev}, 32'd0);
            else                   chk("pulse", {28'd0, ev}, {28'd0, exp_q.pop_front()});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_busy(input logic [3:0] b);
        {i_fetch_busy, i_dis_pipes_active, i_fwd_pipes_active, i_vpus_busy} = b;
    endtask

    task automatic start_run();
        i_start = 1'b1;
        exp_q.push_back(EV_UNHALT);
        cyc(1);
        i_start = 1'b0;
        chk("unhalt_after_start", {31'd0, o_unhalt}, 32'd1);
        chk("busy_after_start", {31'd0, o_glb_busy}, 32'd1);
    endtask

    task automatic sync_cmd(input logic stop, input logic intr);
        i_cmd_sync = 1'b1; i_cmd_sync_stop = stop; i_cmd_sync_intr = intr;
        exp_q.push_back(EV_HALT);
        cyc(1);
        i_cmd_sync = 1'b0; i_cmd_sync_stop = 1'b0; i_cmd_sync_intr = 1'b0;
        chk("halt_after_sync", {31'd0, o_halt}, 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (o_glb_busy && n < 20) begin
            cyc(1);
            n++;
        end
        chk({tag, "_idle_timeout"}, {31'd0, o_glb_busy}, 32'd0);
    endtask

    task automatic finish_scn(input string tag);
        wait_idle(tag);
        cyc(2);
        chk({tag, "_queue_empty"}, exp_q.size(), 32'd0);
        chk({tag, "_stop_drain"}, {31'd0, o_stop_drain}, 32'd0);
        chk({tag, "_glb_busy"}, {31'd0, o_glb_busy}, 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset_outputs", {26'd0, o_glb_busy, o_halt, o_unhalt, o_stop_drain, o_send_intr, o_complete}, 32'd0);
        cyc(2);
        nrst = 1'b1;
        cyc(2);

        // faults and commands in IDLE are ignored
        i_flt_fetch = 1'b1; i_cmd_sync = 1'b1; i_cmd_sync_stop = 1'b1;
        cyc(1);
        i_flt_fetch = 1'b0; i_cmd_sync = 1'b0; i_cmd_sync_stop = 1'b0;
        cyc(2);
        chk("idle_ignores", {30'd0, o_glb_busy, o_stop_drain}, 32'd0);

        // 1: start, sync+stop, busy low after 5 cycles
        set_busy(4'hF);
        start_run();
        cyc(2);
        sync_cmd(1'b1, 1'b0);
        chk("t1_stop_drain", {31'd0, o_stop_drain}, 32'd1);
        cyc(5);
        chk("t1_stop_drain_held", {31'd0, o_stop_drain}, 32'd1);
        chk("t1_busy_held", {31'd0, o_glb_busy}, 32'd1);
        set_busy(4'h0);
        exp_q.push_back(EV_CPL);
        finish_scn("t1");

        // 2: plain sync, resume, then sync+stop+intr
        set_busy(4'hF);
        start_run();
        sync_cmd(1'b0, 1'b0);
        chk("t2_no_drain", {31'd0, o_stop_drain}, 32'd0);
        cyc(5);
        chk("t2_busy_in_sync", {31'd0, o_glb_busy}, 32'd1);
        i_fwd_pipes_active = 1'b0; i_vpus_busy = 1'b0;
        exp_q.push_back(EV_UNHALT);
        cyc(1);
        chk("t2_unhalt_after_drop", {31'd0, o_unhalt}, 32'd1);
        chk("t2_busy_after_resume", {31'd0, o_glb_busy}, 32'd1);
        cyc(2);
        sync_cmd(1'b1, 1'b1);
        cyc(3);
        i_fetch_busy = 1'b0; i_dis_pipes_active = 1'b0;
        exp_q.push_back(EV_CPL_IN);
        finish_scn("t2");

        // 2b: plain sync with intr qualifier raises interrupt with the unhalt
        set_busy(4'hF);
        start_run();
        sync_cmd(1'b0, 1'b1);
        cyc(2);
        i_fwd_pipes_active = 1'b0; i_vpus_busy = 1'b0;
        exp_q.push_back(EV_IN_UNH);
        cyc(3);
        sync_cmd(1'b1, 1'b0);
        set_busy(4'h0);
        exp_q.push_back(EV_CPL);
        finish_scn("t2b");

        // 3: all three faults in RUN
        set_busy(4'hF);
        start_run();
        cyc(1);
        i_flt_fetch = 1'b1; i_flt_decode = 1'b1; i_vpus_err = 1'b1;
        exp_q.push_back(EV_HALT);
        cyc(1);
        i_flt_fetch = 1'b0; i_flt_decode = 1'b0; i_vpus_err = 1'b0;
        chk("t3_halt", {31'd0, o_halt}, 32'd1);
        cyc(2);
        i_vpus_err = 1'b1;
        cyc(1);
        i_vpus_err = 1'b0;
        cyc(3);
        chk("t3_stop_drain_held", {31'd0, o_stop_drain}, 32'd1);
        set_busy(4'h0);
        exp_q.push_back(EV_CPL_IN);
        finish_scn("t3");

        // 4: sync+stop+intr coincident with faults
        set_busy(4'hF);
        start_run();
        i_flt_fetch = 1'b1; i_flt_decode = 1'b1;
        sync_cmd(1'b1, 1'b1);
        i_flt_fetch = 1'b0; i_flt_decode = 1'b0;
        chk("t4_stop_drain", {31'd0, o_stop_drain}, 32'd1);
        set_busy(4'h0);
        exp_q.push_back(EV_CPL_IN);
        finish_scn("t4");

        // 5: NOP (and a stray start) in RUN, then sync+stop+intr
        set_busy(4'hF);
        start_run();
        i_cmd_nop = 1'b1; i_start = 1'b1;
        cyc(1);
        i_cmd_nop = 1'b0; i_start = 1'b0;
        cyc(3);
        chk("t5_nop_no_drain", {31'd0, o_stop_drain}, 32'd0);
        sync_cmd(1'b1, 1'b1);
        set_busy(4'h0);
        exp_q.push_back(EV_CPL_IN);
        finish_scn("t5");

        // 6: reset while draining, then a normal run
        set_busy(4'hF);
        start_run();
        sync_cmd(1'b1, 1'b1);
        cyc(2);
        #2;
        nrst = 1'b0;
        #1;
        chk("t6_reset_outputs", {26'd0, o_glb_busy, o_halt, o_unhalt, o_stop_drain, o_send_intr, o_complete}, 32'd0);
        exp_q.delete();
        cyc(2);
        chk("t6_reset_held", {26'd0, o_glb_busy, o_halt, o_unhalt, o_stop_drain, o_send_intr, o_complete}, 32'd0);
        nrst = 1'b1;
        set_busy(4'h0);
        cyc(2);
        start_run();
        sync_cmd(1'b1, 1'b0);
        exp_q.push_back(EV_CPL);
        finish_scn("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
